// File: rtl/crc_stream_engine.sv
// crc_stream_engine: framed, multi-bit-per-cycle CRC generator/checker.
// Consumes DATA_W bits per beat (MSB first) under a valid/ready/last handshake
// and, one cycle after the last beat, pulses crc_valid with the frame CRC and a
// flag that is set when the raw remainder is zero.
// Optional feature: define CRC_XOROUT_EN to apply XOR_OUT to crc_out
// (crc_match always uses the raw remainder).
module crc_stream_engine #(
  parameter int                 CRC_W   = 4,
  parameter logic [CRC_W-1:0]   POLY    = 4'h3,
  parameter logic [CRC_W-1:0]   INIT    = '0,
  parameter int                 DATA_W  = 1,
  parameter logic [CRC_W-1:0]   XOR_OUT = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              crc_match
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

`ifdef CRC_XOROUT_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif
  // Mask folded into crc_out only; the match flag never sees it.
  localparam logic [CRC_W-1:0] OUT_MASK = XOR_EN ? XOR_OUT : '0;

  // Direct (non-augmented) CRC over one beat, bit DATA_W-1 first.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = d[i] ^ r[CRC_W-1];
      r  = (r << 1) ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  logic [1:0]       state;
  logic [CRC_W-1:0] crc_p0;
  logic [CRC_W-1:0] crc_base;
  logic [CRC_W-1:0] crc_next;
  logic             accept;
  logic             accept_last;

  // Ready is withheld while in reset and during the single DONE cycle.
  assign data_ready  = reset_n && (state != S_DONE);
  assign accept      = data_valid && data_ready;
  assign accept_last = accept && data_last;

  // Next remainder; a frame's first beat always starts from INIT.
  always_comb begin
    crc_base = (state == S_IDLE) ? INIT : crc_p0;
    crc_next = crc_step(crc_base, data_in);
  end

  // Frame FSM and the one-cycle result strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= accept_last;
      case (state)
        S_IDLE, S_ACTIVE: begin
          if (accept) state <= data_last ? S_DONE : S_ACTIVE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p0: running remainder, reloaded with INIT outside a frame ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_p0 <= INIT;
    end else if (accept_last) begin
      crc_p0 <= INIT;
    end else if (accept) begin
      crc_p0 <= crc_next;
    end else if (state != S_ACTIVE) begin
      crc_p0 <= INIT;
    end
  end

  // ---- result stage: captured with the last beat, held until the next frame ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_out   <= '0;
      crc_match <= 1'b0;
    end else if (accept_last) begin
      crc_out   <= crc_next ^ OUT_MASK;
      crc_match <= (crc_next == '0);
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Testbench for crc_stream_engine: two instances (1-bit and 4-bit beats),
// a vector table, hand-written corner sequences and random frames checked
// against a polynomial long-division reference model.
module tb_crc_stream_engine;

  localparam logic [3:0] POLY = 4'h3;
`ifdef CRC_XOROUT_EN
  localparam logic [3:0] XM = 4'hF;
`else
  localparam logic [3:0] XM = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [0:0] d1;
  logic       v1, l1, r1, cv1, m1;
  logic [3:0] c1;
  logic [3:0] d4;
  logic       v4, l4, r4, cv4, m4;
  logic [3:0] c4;

  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_W(4), .POLY(4'h3), .INIT(4'h0), .DATA_W(1), .XOR_OUT(4'hF)) u1 (
    .clk(clk), .reset_n(reset_n), .data_in(d1), .data_valid(v1), .data_last(l1),
    .data_ready(r1), .crc_out(c1), .crc_valid(cv1), .crc_match(m1));

  crc_stream_engine #(.CRC_W(4), .POLY(4'h3), .INIT(4'h0), .DATA_W(4), .XOR_OUT(4'hF)) u4 (
    .clk(clk), .reset_n(reset_n), .data_in(d4), .data_valid(v4), .data_last(l4),
    .data_ready(r4), .crc_out(c4), .crc_valid(cv4), .crc_match(m4));

  int         sel;
  logic       cur_ready, cur_cv, cur_match;
  logic [3:0] cur_crc;
  int         n_pass, n_total;

  always_comb begin
    cur_ready = (sel == 4) ? r4  : r1;
    cur_cv    = (sel == 4) ? cv4 : cv1;
    cur_match = (sel == 4) ? m4  : m1;
    cur_crc   = (sel == 4) ? c4  : c1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Remainder of M(x)*x^4 mod G(x) by plain long division on a bit list.
  function automatic logic [3:0] model(input int w, input logic [3:0] beats[$]);
    bit         dv[$];
    logic [4:0] g;
    int         n;
    g = {1'b1, POLY};
    foreach (beats[k])
      for (int b = w - 1; b >= 0; b--) dv.push_back(beats[k][b]);
    n = dv.size();
    repeat (4) dv.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (dv[i])
        for (int j = 0; j <= 4; j++) dv[i+j] = dv[i+j] ^ g[4-j];
    return {dv[n], dv[n+1], dv[n+2], dv[n+3]};
  endfunction

  task automatic drive(input logic v, input logic [3:0] d, input logic l);
    @(negedge clk);
    if (sel == 4) begin v4 = v; d4 = d; l4 = l; end
    else begin v1 = v; d1 = d[0]; l1 = l; end
  endtask

  // Idle cycle with junk on data/last, which must be ignored.
  task automatic idle();
    drive(1'b0, 4'($urandom), 1'($urandom));
  endtask

  task automatic push_beat(input logic [3:0] d, input logic l, input string nm);
    int t;
    drive(1'b1, d, l);
    t = 0;
    while (!cur_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (t >= 8) chk({nm, "_ready_timeout"}, cur_ready, 1);
    @(posedge clk);
  endtask

  task automatic finish_check(input logic [3:0] exp_raw, input string nm);
    idle();
    chk({nm, "_valid"}, cur_cv, 1);
    chk({nm, "_crc"},   cur_crc, exp_raw ^ XM);
    chk({nm, "_match"}, cur_match, (exp_raw == 4'h0));
    chk({nm, "_ready_done"}, cur_ready, 0);
    @(negedge clk);
    chk({nm, "_pulse_end"}, cur_cv, 0);
  endtask

  task automatic run_frame(input int s, input logic [3:0] beats[$], input int gap,
                           input logic [3:0] exp_raw, input string nm);
    sel = s;
    foreach (beats[i]) begin
      if (i > 0) repeat (gap) idle();
      push_beat(beats[i], (i == beats.size() - 1), nm);
    end
    finish_check(exp_raw, nm);
  endtask

  typedef struct {
    int          w;
    int          nb;
    logic [43:0] bits;
    logic [3:0]  exp;
    string       nm;
  } vec_t;

  vec_t       tbl[7];
  logic [3:0] q[$];
  logic [3:0] bt;
  logic [3:0] e;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0; sel = 1;
    v1 = 0; l1 = 0; d1 = 0; v4 = 0; l4 = 0; d4 = 0;
    reset_n = 0;

    tbl[0] = '{1, 7,  44'b1011001,     4'hA, "v_1011001"};
    tbl[1] = '{1, 11, 44'b10110011010, 4'h0, "v_appended"};
    tbl[2] = '{4, 2,  44'hB2,          4'h7, "v_b2"};
    tbl[3] = '{4, 3,  44'hB27,         4'h0, "v_b27"};
    tbl[4] = '{1, 1,  44'b1,           4'h3, "v_single1"};
    tbl[5] = '{1, 1,  44'b0,           4'h0, "v_single0"};
    tbl[6] = '{4, 1,  44'h0,           4'h0, "v_nib0"};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready1", r1, 0);
    chk("rst_ready4", r4, 0);
    chk("rst_valid",  cv1, 0);
    chk("rst_crc1",   c1, 0);
    chk("rst_match1", m1, 0);
    chk("rst_crc4",   c4, 0);
    reset_n = 1;
    @(negedge clk);
    chk("post_rst_ready1", r1, 1);
    chk("post_rst_ready4", r4, 1);

    // Vector table
    for (int t = 0; t < 7; t++) begin
      q = {};
      for (int k = 0; k < tbl[t].nb; k++) begin
        bt = 4'h0;
        for (int b = 0; b < tbl[t].w; b++) bt[b] = tbl[t].bits[(tbl[t].nb - 1 - k) * tbl[t].w + b];
        q.push_back(bt);
      end
      run_frame(tbl[t].w, q, 0, tbl[t].exp, tbl[t].nm);
    end

    // Gaps between beats do not disturb the remainder
    q = {4'hB, 4'h2};
    run_frame(4, q, 3, 4'h7, "gap3");

    // Back-to-back: next frame's first beat held across the DONE cycle
    sel = 4;
    push_beat(4'hB, 1'b0, "b2b_a");
    push_beat(4'h2, 1'b1, "b2b_a");
    drive(1'b1, 4'hB, 1'b0);
    chk("b2b_a_valid", cv4, 1);
    chk("b2b_a_crc", c4, 4'h7 ^ XM);
    chk("b2b_ready_done", r4, 0);
    @(negedge clk);
    chk("b2b_ready_idle", r4, 1);
    chk("b2b_valid_low", cv4, 0);
    @(posedge clk);
    push_beat(4'h2, 1'b1, "b2b_b");
    finish_check(4'h7, "b2b_b");

    // Reset in the middle of a frame
    sel = 1;
    push_beat(4'h1, 1'b0, "midrst");
    push_beat(4'h0, 1'b0, "midrst");
    push_beat(4'h1, 1'b0, "midrst");
    @(negedge clk);
    reset_n = 0; v1 = 0;
    @(negedge clk);
    chk("midrst_ready_in_rst", r1, 0);
    reset_n = 1;
    chk("midrst_crc_cleared", c1, 0);
    chk("midrst_no_valid", cv1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_valid_later", cv1, 0);
    end
    q = {4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1};
    run_frame(1, q, 0, 4'hA, "midrst_after");

    // Random frames against the division model
    for (int n = 0; n < 40; n++) begin
      int w;
      w = (n % 2 == 1) ? 4 : 1;
      q = {};
      for (int k = 0; k < $urandom_range(1, 10); k++)
        q.push_back((w == 4) ? 4'($urandom) : {3'b0, 1'($urandom)});
      if ($urandom_range(0, 1) == 1) begin
        e = model(w, q);
        if (w == 4) q.push_back(e);
        else for (int b = 3; b >= 0; b--) q.push_back({3'b0, e[b]});
      end
      run_frame(w, q, $urandom_range(0, 2), model(w, q), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
